// File: rtl/ascon_pack.sv
// Shared ASCON types and constants: 5x64 state, round constants, S-box, permutation FSM states.
package ascon_pack;

  // Index 0 is x0 (the S-box column MSB); {x0,x1,x2,x3,x4} concatenates naturally.
  typedef logic [0:4][63:0] type_state;

  localparam int NB_ROUNDS_MAX = 12;

  localparam logic [0:31][4:0] SBOX = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} type_perm_fsm;

  function automatic logic [7:0] round_const(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bit-sliced S-box layer, diffusion.
module ascon_round
  import ascon_pack::*;
#(
  parameter int CNT_W = 4
) (
  input  type_state        state_i,
  input  logic [CNT_W-1:0] round_i,
  output type_state        state_o
);

  type_state add, sub;
  logic [4:0] col, sb;

  always_comb begin
    add = state_i;
    add[2][7:0] = state_i[2][7:0] ^ round_const(4'(round_i));
    sub = '0;
    col = '0;
    sb  = '0;
    // Each bit position forms a 5-bit column with x0 as its MSB.
    for (int b = 0; b < 64; b++) begin
      col = {add[0][b], add[1][b], add[2][b], add[3][b], add[4][b]};
      sb  = SBOX[col];
      for (int k = 0; k < 5; k++) sub[k][b] = sb[4-k];
    end
  end

  diffusion u_diff (
    .state_i(sub),
    .state_o(state_o)
  );

endmodule

// File: rtl/diffusion.sv
// ASCON linear diffusion layer: each word XORed with two rotations of itself.
module diffusion
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign state_o[0] = state_i[0] ^ ror(state_i[0], 19) ^ ror(state_i[0], 28);
  assign state_o[1] = state_i[1] ^ ror(state_i[1], 61) ^ ror(state_i[1], 39);
  assign state_o[2] = state_i[2] ^ ror(state_i[2], 1)  ^ ror(state_i[2], 6);
  assign state_o[3] = state_i[3] ^ ror(state_i[3], 10) ^ ror(state_i[3], 17);
  assign state_o[4] = state_i[4] ^ ror(state_i[4], 7)  ^ ror(state_i[4], 41);

endmodule

// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON permutation p^a/p^b, one round per clock.
// Define ASCON_PERM_UNROLL2_EN to chain two rounds per RUN cycle.
module ascon_permutation_iter
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS_MAX = ascon_pack::NB_ROUNDS_MAX,
  parameter int CNT_W         = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] nb_rounds_i,
  input  type_state        state_i,
  output logic             ready_o,
  output logic             done_o,
  output type_state        state_o
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(NB_ROUNDS_MAX);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NB_ROUNDS_MAX - 1);

  type_perm_fsm     fsm_q, fsm_d;
  type_state        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  type_state        r0_out;
  logic             nb_legal;

  assign nb_legal = (nb_rounds_i != '0) && (nb_rounds_i <= MAX_C);
  assign state_o  = state_q;

  ascon_round #(.CNT_W(CNT_W)) u_round0 (
    .state_i(state_q),
    .round_i(cnt_q),
    .state_o(r0_out)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  type_state r1_out;

  ascon_round #(.CNT_W(CNT_W)) u_round1 (
    .state_i(r0_out),
    .round_i(cnt_q + CNT_W'(1)),
    .state_o(r1_out)
  );
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    case (fsm_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i && nb_legal) begin
          state_d = state_i;
          cnt_d   = MAX_C - nb_rounds_i;
          fsm_d   = RUN;
        end
      end
      RUN: begin
`ifdef ASCON_PERM_UNROLL2_EN
        // Odd round counts finish with a single round from the first instance.
        if (cnt_q == LAST_C) begin
          state_d = r0_out;
          cnt_d   = cnt_q + CNT_W'(1);
          fsm_d   = DONE;
        end else begin
          state_d = r1_out;
          cnt_d   = cnt_q + CNT_W'(2);
          if (cnt_q == LAST_C - CNT_W'(1)) fsm_d = DONE;
        end
`else
        state_d = r0_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_C) fsm_d = DONE;
`endif
      end
      DONE: begin
        done_o = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Randomized bench for ascon_permutation_iter against a behavioural permutation/timing model.
module tb_ascon_permutation_iter;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         start_i;
  logic [3:0]   nb_rounds_i;
  logic [319:0] state_i;
  logic         ready_o;
  logic         done_o;
  logic [319:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock_i = ~clock_i;

  ascon_permutation_iter dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .nb_rounds_i(nb_rounds_i),
    .state_i    (state_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .state_o    (state_o)
  );

  localparam logic [4:0] SB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [7:0] m_const(input int i);
    return 8'((15 - i) * 16 + i);
  endfunction

  function automatic logic [63:0] m_rot(input logic [63:0] v, input int n);
    logic [127:0] t;
    t = {v, v} >> n;
    return t[63:0];
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int i);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  c, o;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    x[2] = x[2] ^ {56'd0, m_const(i)};
    for (int b = 0; b < 64; b++) begin
      c = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SB[c];
      for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
    end
    x[0] = y[0] ^ m_rot(y[0], 19) ^ m_rot(y[0], 28);
    x[1] = y[1] ^ m_rot(y[1], 61) ^ m_rot(y[1], 39);
    x[2] = y[2] ^ m_rot(y[2], 1)  ^ m_rot(y[2], 6);
    x[3] = y[3] ^ m_rot(y[3], 10) ^ m_rot(y[3], 17);
    x[4] = y[4] ^ m_rot(y[4], 7)  ^ m_rot(y[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int n);
    logic [319:0] r;
    r = s;
    for (int i = 12 - n; i < 12; i++) r = m_round(r, i);
    return r;
  endfunction

  function automatic int m_lat(input int n);
`ifdef ASCON_PERM_UNROLL2_EN
    return (n + 1) / 2;
`else
    return n;
`endif
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Timing model: samples remaining until idle; the done pulse is the last busy sample.
  int           cyc = 0;
  int           m_left = 0;
  logic [319:0] m_res = '0;
  bit           chk_en = 0;
  int           done_last = -1, done_prev = -1;

  always @(posedge clock_i) begin
    cyc++;
    if (reset_i) begin
      m_left = 0;
      m_res  = '0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (start_i && nb_rounds_i >= 1 && nb_rounds_i <= 12) begin
      m_res  = m_perm(state_i, int'(nb_rounds_i));
      m_left = m_lat(int'(nb_rounds_i)) + 1;
    end
  end

  always @(negedge clock_i) begin
    if (chk_en) begin
      chk("ready", 320'(ready_o), 320'(m_left == 0));
      chk("done", 320'(done_o), 320'(m_left == 1));
      if (m_left <= 1) chk("state", state_o, m_res);
      if (done_o) begin
        done_prev = done_last;
        done_last = cyc;
      end
    end
  end

  task automatic cycle();
    @(posedge clock_i);
    #2;
  endtask

  task automatic go(input logic [319:0] s, input int n);
    int w;
    w = 0;
    while (!ready_o && w < 50) begin
      cycle();
      w++;
    end
    if (!ready_o) begin
      n_chk++;
      $display("FAIL ready_timeout: ready_o=%0b expected 1 within 50 cycles", ready_o);
    end
    state_i     = s;
    nb_rounds_i = 4'(n);
    start_i     = 1'b1;
    cycle();
    start_i     = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done_o && w < 40) begin
      cycle();
      w++;
    end
    if (!done_o) begin
      n_chk++;
      $display("FAIL done_timeout: done_o=%0b expected 1 within 40 cycles", done_o);
    end
  endtask

  function automatic logic [319:0] rnd_state();
    logic [319:0] s;
    for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  logic [319:0] tmp, s0;

  initial begin
    reset_i = 1'b1; start_i = 1'b0; nb_rounds_i = '0; state_i = '0;
    cycle(); cycle();
    chk_en = 1;
    reset_i = 1'b0;
    cycle();

    // Pin the model's constant schedule and a hand-derived single round.
    chk("const0", 320'(m_const(0)), 320'(8'hF0));
    chk("const6", 320'(m_const(6)), 320'(8'h96));
    chk("const4", 320'(m_const(4)), 320'(8'hB4));
    chk("const11", 320'(m_const(11)), 320'(8'h4B));
    tmp = m_round('0, 11);
    chk("model_x0", 320'(tmp[319:256]), 320'(64'h000964B00000004B));
    chk("model_x1", 320'(tmp[255:192]), 320'(64'h0000000096000213));

    // Single round from zero: constant 0x4B.
    go('0, 1);
    wait_done();
    tmp = state_o;
    chk("r1_x0", 320'(tmp[319:256]), 320'(64'h000964B00000004B));
    chk("r1_x1", 320'(tmp[255:192]), 320'(64'h0000000096000213));
    chk("r1_x3", 320'(tmp[127:64]),  320'(64'h12E580000000004B));
    chk("r1_x4", 320'(tmp[63:0]),    320'(64'h0));
    cycle();

    // p12 on an ASCON-128 initial state, then p6 and p8 on random states.
    s0 = rnd_state();
    s0[319:256] = 64'h80400c0600000000;
    go(s0, 12); wait_done(); cycle();
    go(rnd_state(), 6); wait_done(); cycle();
    go(rnd_state(), 8); wait_done(); cycle();

    // Illegal round counts are ignored.
    go(rnd_state(), 0); cycle(); cycle();
    go(rnd_state(), 13); cycle(); cycle();
    go(rnd_state(), 15); cycle(); cycle();

    // Reset in the middle of p12.
    go(rnd_state(), 12);
    repeat (5) cycle();
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    repeat (3) cycle();

    // Start held high: back-to-back p6 runs spaced by latency+2.
    state_i = rnd_state(); nb_rounds_i = 4'd6; start_i = 1'b1;
    repeat (3 * (m_lat(6) + 2) + 2) cycle();
    start_i = 1'b0;
    chk("b2b_gap", 320'(done_last - done_prev), 320'(m_lat(6) + 2));
    repeat (12) cycle();

    // Random traffic, including illegal counts and idle gaps.
    for (int t = 0; t < 30; t++) begin
      go(rnd_state(), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) cycle();
    end
    repeat (20) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_iter.md
Name: ascon_permutation_iter

Overview:
- Iterative ASCON permutation engine (p^a / p^b).
- Holds the 320-bit state in a register and applies one full round per clock: constant addition, substitution layer, linear diffusion.
- Sits between the mode FSM (init/AD/plaintext/finalisation) and the combinational round logic.
- Linear diffusion is the existing team module `diffusion`, driven by the substitution-layer output.

Parameters:
- NB_ROUNDS_MAX, 12, total rounds of p^a; round index base for constants.
- CNT_W, 4, width of round counter and nb_rounds_i.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  request permutation; sampled only when ready_o=1.
- nb_rounds_i  in  CNT_W  rounds to run; legal 1..12 (6/8/12 in practice).
- state_i  in  type_state (5x64)  state loaded on accepted start.
- ready_o  out  1  engine idle, start accepted.
- done_o  out  1  one-cycle pulse: state_o holds the result.
- state_o  out  type_state  current state register.

Behaviour:
- Reset (sync, reset_i=1 at edge): FSM=IDLE, state register=0, counter=0, ready_o=1, done_o=0. Reset has priority over everything, including mid-RUN; the in-flight result is discarded and no done_o is raised.
- FSM states:
  - IDLE: ready_o=1. Accepted start (start_i=1 and nb_rounds_i in 1..12): at that edge, state<=state_i, cnt<=NB_ROUNDS_MAX-nb_rounds_i, go RUN.
  - IDLE, illegal nb_rounds_i (0 or >12): start ignored, stay IDLE, state unchanged.
  - RUN: ready_o=0. Each edge: state<=round(state, cnt), cnt<=cnt+1. When cnt==NB_ROUNDS_MAX-1 at the edge, go DONE.
  - DONE: ready_o=0, done_o=1 for exactly this cycle. Next edge goes to IDLE. start_i in DONE is ignored.
- Latency: start accepted at edge E; done_o high in the cycle after edge E+nb_rounds. Start-to-next-start = nb_rounds+2 cycles.
- Round function round(s,i):
  - Constant c=((4'hF-i)<<4)|i, XORed into s[2][7:0]. Examples: i=0 gives 0xF0, i=6 gives 0x96, i=4 gives 0xB4, i=11 gives 0x4B.
  - Substitution: 5-bit ASCON S-box on each of the 64 bit-columns, x0 = MSB of the column.
  - Diffusion: existing `diffusion` module.
- state_o = state register at all times; holds the result after DONE until the next accepted start or reset.
- Inputs state_i/nb_rounds_i are don't-care except at the accepting edge.

Optional Feature:
- Macro ASCON_PERM_UNROLL2_EN.
- Defined: two chained round instances; each RUN cycle applies rounds cnt and cnt+1 and advances cnt by 2. If exactly one round remains, only the first instance's output is registered. RUN lasts ceil(nb_rounds/2) cycles; done_o and IDLE/DONE semantics are unchanged.
- Undefined: single round instance, one round per cycle, as above.
- Results must be bit-identical in both builds.

Decomposition:
- ascon_pack additions:
  - NB_ROUNDS_MAX constant.
  - Function round_const(i) returning 8 bits.
  - S-box LUT constant (32x5).
  - FSM enum type_perm_fsm {IDLE, RUN, DONE}.
- type_state is reused from ascon_pack.
- Sub-module ascon_round: combinational, inputs state and round index, output state. Contains constant addition, the S-box layer, and a `diffusion` instance. ascon_permutation_iter instantiates one (or two with the macro) plus the FSM, counter and state register.

Test Plan:
- Reset mid-RUN: start nb_rounds=12, assert reset_i after 5 cycles -> next cycle ready_o=1, state_o=0, no done_o pulse.
- Constant check: state_i all-zero, nb_rounds=1 -> done_o one cycle after edge E+1. state_o equals diffusion of {0x4B, 0x4B, 0xFFFFFFFFFFFFFFB4, 0x4B, 0}, i.e. the single-round result with constant 0x4B.
- Full p12 on ASCON-128 IV state (0x80400c0600000000, key, nonce) -> state_o matches the C golden model. done_o at start edge+13 cycles; ready_o=0 for 13 cycles.
- p6 and p8 from random states -> match golden model. Latency 7 and 9 cycles; first constants 0x96 and 0xB4 observed via single-round probes.
- Illegal nb_rounds 0 and 13 with start_i=1 -> ready_o stays 1, state_o unchanged, no done_o.
- Start held high through DONE -> restart only from IDLE: back-to-back p6 runs spaced 8 cycles. Repeat all scenarios with ASCON_PERM_UNROLL2_EN defined: identical states, latency ceil(n/2)+2.
